// File: rtl/leaf_share_arbiter.sv
// leaf_share_arbiter
// Shares one BFT leaf port between the two pages of a double-subdivided
// partial-reconfiguration region.
//   Egress : each page's outbound packets go into a small FIFO. The FIFOs are
//            merged round-robin onto dout_leaf_interface2bft. When the BFT
//            raises resend, the last driven packet is driven again.
//   Ingress: din_leaf_bft2interface is steered to page 0 or page 1 by its
//            destination-leaf field. Valid packets that match neither page are
//            dropped and counted.
// Ports:
//   clk_400, reset_400            - clock, asynchronous active-high reset
//   din_leaf_bft2interface        - packet from the BFT
//   dout_leaf_interface2bft       - merged packet to the BFT (registered)
//   resend                        - BFT rejected the previously driven packet
//   din_leaf_bft2interface_0/_1   - demuxed packet to page 0/1 (registered)
//   dout_leaf_interface2bft_0/_1  - outbound packet from page 0/1
//   resend_0/_1                   - page packet of last cycle was not captured
//   drop_count                    - saturating count of unroutable ingress packets
module leaf_share_arbiter #(
  parameter int unsigned PKT_W      = 49,
  parameter int unsigned ADDR_HI    = 47,
  parameter int unsigned ADDR_LO    = 43,
  parameter logic [ADDR_HI-ADDR_LO:0] PAGE0_ADDR = 5'd2,
  parameter logic [ADDR_HI-ADDR_LO:0] PAGE1_ADDR = 5'd3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_400,
  input  logic             reset_400,
  input  logic [PKT_W-1:0] din_leaf_bft2interface,
  output logic [PKT_W-1:0] dout_leaf_interface2bft,
  input  logic             resend,
  output logic [PKT_W-1:0] din_leaf_bft2interface_0,
  output logic [PKT_W-1:0] din_leaf_bft2interface_1,
  input  logic [PKT_W-1:0] dout_leaf_interface2bft_0,
  input  logic [PKT_W-1:0] dout_leaf_interface2bft_1,
  output logic             resend_0,
  output logic             resend_1,
  output logic [15:0]      drop_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PKT_W-1:0] PKT_ZERO = {PKT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_RETRY = 2'd2
  } state_t;

  // Egress FIFO storage, one per page
  logic [PKT_W-1:0] page_pkt_s [2];
  logic [PKT_W-1:0] fifo_mem_r [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r   [2];
  logic [PTR_W-1:0] rd_ptr_r   [2];
  logic [CNT_W-1:0] count_r    [2];
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       nonempty_s;
  logic [1:0]       full_s;
  logic [1:0]       page_resend_r;

  // Egress merge FSM
  state_t           state_r, state_s;
  logic [PKT_W-1:0] out_r, out_s;
  logic [PKT_W-1:0] saved_r, saved_s;
  logic             last_grant_r, last_grant_s;
  logic             grant_s;

  // Ingress demux
  logic [PKT_W-1:0] in0_r, in0_s;
  logic [PKT_W-1:0] in1_r, in1_s;
  logic [15:0]      drop_r, drop_s;
  logic             in_valid_s;
  logic             hit0_s;
  logic             hit1_s;

  assign page_pkt_s[0] = dout_leaf_interface2bft_0;
  assign page_pkt_s[1] = dout_leaf_interface2bft_1;

  // FIFO status and capture decision; fullness uses the registered count so a
  // same-cycle pop never makes room for a push.
  always_comb begin
    push_s     = 2'b00;
    nonempty_s = 2'b00;
    full_s     = 2'b00;
    for (int p = 0; p < 2; p++) begin
      nonempty_s[p] = (count_r[p] != {CNT_W{1'b0}});
      full_s[p]     = (count_r[p] >= DEPTH_C);
      push_s[p]     = page_pkt_s[p][PKT_W-1] & ~full_s[p];
    end
  end

  // Per-page FIFO pointers, occupancy and page-side resend flag
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr_r[p] <= {PTR_W{1'b0}};
        rd_ptr_r[p] <= {PTR_W{1'b0}};
        count_r[p]  <= {CNT_W{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          fifo_mem_r[p][i] <= PKT_ZERO;
        end
      end
      page_resend_r <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push_s[p]) begin
          fifo_mem_r[p][wr_ptr_r[p]] <= page_pkt_s[p];
          wr_ptr_r[p] <= wr_ptr_r[p] + PTR_W'(1'b1);
        end
        if (pop_s[p]) begin
          rd_ptr_r[p] <= rd_ptr_r[p] + PTR_W'(1'b1);
        end
        count_r[p]       <= count_r[p] + CNT_W'(push_s[p]) - CNT_W'(pop_s[p]);
        page_resend_r[p] <= page_pkt_s[p][PKT_W-1] & full_s[p];
      end
    end
  end

  // Merge FSM next state: retry beats send beats idle. A resend while the
  // output is invalid is ignored.
  always_comb begin
    state_s      = ST_IDLE;
    out_s        = PKT_ZERO;
    saved_s      = saved_r;
    last_grant_s = last_grant_r;
    grant_s      = 1'b0;
    pop_s        = 2'b00;
    if (resend && (state_r != ST_IDLE) && out_r[PKT_W-1]) begin
      state_s = ST_RETRY;
      out_s   = saved_r;
    end else if (nonempty_s != 2'b00) begin
      // On a tie the page that did not win last time goes next; otherwise
      // the only non-empty page wins.
      if (nonempty_s == 2'b11) begin
        grant_s = ~last_grant_r;
      end else begin
        grant_s = nonempty_s[1];
      end
      state_s      = ST_SEND;
      out_s        = fifo_mem_r[grant_s][rd_ptr_r[grant_s]];
      saved_s      = out_s;
      last_grant_s = grant_s;
      pop_s        = grant_s ? 2'b10 : 2'b01;
    end else begin
      state_s = ST_IDLE;
    end
  end

  // Merge FSM registers; last_grant resets to 1 so page 0 wins the first tie
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      state_r      <= ST_IDLE;
      out_r        <= PKT_ZERO;
      saved_r      <= PKT_ZERO;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      out_r        <= out_s;
      saved_r      <= saved_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Ingress routing by destination leaf and saturating drop counter
  always_comb begin
    in_valid_s = din_leaf_bft2interface[PKT_W-1];
    hit0_s     = (din_leaf_bft2interface[ADDR_HI:ADDR_LO] == PAGE0_ADDR);
    hit1_s     = (din_leaf_bft2interface[ADDR_HI:ADDR_LO] == PAGE1_ADDR);
    in0_s      = PKT_ZERO;
    in1_s      = PKT_ZERO;
    drop_s     = drop_r;
    if (in_valid_s && hit0_s) begin
      in0_s = din_leaf_bft2interface;
    end else if (in_valid_s && hit1_s) begin
      in1_s = din_leaf_bft2interface;
    end else if (in_valid_s && (drop_r != 16'hFFFF)) begin
      drop_s = drop_r + 16'd1;
    end else begin
      drop_s = drop_r;
    end
  end

  // Ingress output registers
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      in0_r  <= PKT_ZERO;
      in1_r  <= PKT_ZERO;
      drop_r <= 16'd0;
    end else begin
      in0_r  <= in0_s;
      in1_r  <= in1_s;
      drop_r <= drop_s;
    end
  end

  assign dout_leaf_interface2bft  = out_r;
  assign din_leaf_bft2interface_0 = in0_r;
  assign din_leaf_bft2interface_1 = in1_r;
  assign resend_0                 = page_resend_r[0];
  assign resend_1                 = page_resend_r[1];
  assign drop_count               = drop_r;

endmodule

// File: tb/tb_leaf_share_arbiter.sv
// Self-checking bench for leaf_share_arbiter. A queue-based reference model
// predicts every output each cycle; stimulus is randomized in phases with a
// few directed sequences.
module tb_leaf_share_arbiter;

  localparam int DEPTH = 4;
  localparam logic [48:0] PKT1 = {1'b1, 5'd9, 43'h1};

  logic        clk_400 = 1'b0;
  logic        reset_400 = 1'b1;
  logic [48:0] din_bft = '0;
  logic [48:0] dout_bft;
  logic        resend = 1'b0;
  logic [48:0] din_p0, din_p1;
  logic [48:0] pg0 = '0, pg1 = '0;
  logic        rs0, rs1;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [48:0] q0[$];
  logic [48:0] q1[$];
  logic [48:0] m_out = '0, m_saved = '0, m_in0 = '0, m_in1 = '0;
  int          m_last = 1;
  bit          m_rs0 = 0, m_rs1 = 0;
  int          m_drop = 0;
  int unsigned seq0 = 0, seq1 = 0;

  leaf_share_arbiter dut (
    .clk_400                   (clk_400),
    .reset_400                 (reset_400),
    .din_leaf_bft2interface    (din_bft),
    .dout_leaf_interface2bft   (dout_bft),
    .resend                    (resend),
    .din_leaf_bft2interface_0  (din_p0),
    .din_leaf_bft2interface_1  (din_p1),
    .dout_leaf_interface2bft_0 (pg0),
    .dout_leaf_interface2bft_1 (pg1),
    .resend_0                  (rs0),
    .resend_1                  (rs1),
    .drop_count                (drop_count)
  );

  always #5 clk_400 = ~clk_400;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_out = '0; m_saved = '0; m_in0 = '0; m_in1 = '0;
    m_last = 1; m_rs0 = 0; m_rs1 = 0; m_drop = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held at the edge
  task automatic model_edge();
    int s0, s1, g;
    logic [4:0] a;
    if (reset_400) begin
      model_reset();
      return;
    end
    s0 = q0.size();
    s1 = q1.size();
    if (resend && m_out[48]) begin
      m_out = m_saved;
    end else if (s0 > 0 || s1 > 0) begin
      if (s0 > 0 && s1 > 0) g = 1 - m_last;
      else g = (s0 > 0) ? 0 : 1;
      m_out = (g == 0) ? q0.pop_front() : q1.pop_front();
      m_saved = m_out;
      m_last = g;
    end else begin
      m_out = '0;
    end
    m_rs0 = pg0[48] && (s0 >= DEPTH);
    m_rs1 = pg1[48] && (s1 >= DEPTH);
    if (pg0[48] && s0 < DEPTH) q0.push_back(pg0);
    if (pg1[48] && s1 < DEPTH) q1.push_back(pg1);
    a = din_bft[47:43];
    m_in0 = (din_bft[48] && a == 5'd2) ? din_bft : '0;
    m_in1 = (din_bft[48] && a == 5'd3) ? din_bft : '0;
    if (din_bft[48] && a != 5'd2 && a != 5'd3 && m_drop < 65535) m_drop++;
  endtask

  task automatic compare_all();
    check_val("dout", {15'd0, dout_bft}, {15'd0, m_out});
    check_val("in0", {15'd0, din_p0}, {15'd0, m_in0});
    check_val("in1", {15'd0, din_p1}, {15'd0, m_in1});
    check_val("resend_0", {63'd0, rs0}, {63'd0, m_rs0});
    check_val("resend_1", {63'd0, rs1}, {63'd0, m_rs1});
    check_val("drop_count", {48'd0, drop_count}, m_drop);
  endtask

  task automatic step();
    @(posedge clk_400);
    model_edge();
    #1;
    compare_all();
  endtask

  // New inputs for the coming cycle; a rejected page packet is re-presented
  task automatic drive(input int pv0, input int pv1, input int pres, input int pin);
    logic [4:0] a;
    if (!m_rs0) begin
      if ($urandom_range(99) < pv0) begin
        seq0++;
        pg0 = {1'b1, 5'd9, 11'd0, seq0};
      end else pg0 = '0;
    end
    if (!m_rs1) begin
      if ($urandom_range(99) < pv1) begin
        seq1++;
        pg1 = {1'b1, 5'd10, 11'd1, seq1};
      end else pg1 = '0;
    end
    resend = ($urandom_range(99) < pres);
    case ($urandom_range(3))
      0: a = 5'd2;
      1: a = 5'd3;
      2: a = 5'd7;
      default: a = 5'($urandom);
    endcase
    din_bft = {($urandom_range(99) < pin), a, 11'($urandom), 32'($urandom)};
  endtask

  task automatic run_phase(input int n, input int pv0, input int pv1, input int pres, input int pin);
    for (int i = 0; i < n; i++) begin
      drive(pv0, pv1, pres, pin);
      step();
    end
  endtask

  initial begin
    // reset held for a few edges
    for (int i = 0; i < 3; i++) step();
    reset_400 = 1'b0;

    // single packet from page 0: visible only two cycles later
    pg0 = PKT1;
    step();
    pg0 = '0;
    check_val("tp1_cycle1", {15'd0, dout_bft}, 64'd0);
    step();
    check_val("tp1_cycle2", {15'd0, dout_bft}, {15'd0, PKT1});
    step();
    check_val("tp1_cycle3", {15'd0, dout_bft}, 64'd0);
    run_phase(3, 0, 0, 0, 0);

    // both pages streaming, no resend
    run_phase(8, 100, 100, 0, 0);
    run_phase(6, 0, 0, 0, 0);

    // page 0 streaming with a 3-cycle resend burst, then release
    run_phase(2, 100, 0, 0, 0);
    run_phase(3, 100, 0, 100, 0);
    run_phase(12, 100, 0, 0, 0);
    run_phase(6, 0, 0, 0, 0);

    // ingress addresses 2, 3, 7 back to back
    din_bft = {1'b1, 5'd2, 43'h111}; step();
    din_bft = {1'b1, 5'd3, 43'h222}; step();
    din_bft = {1'b1, 5'd7, 43'h333}; step();
    din_bft = '0; step();

    // mixed random traffic
    run_phase(300, 50, 50, 20, 60);
    run_phase(200, 100, 100, 50, 80);
    run_phase(200, 90, 90, 0, 50);

    // asynchronous reset in the middle of a retry with backed-up FIFOs
    run_phase(2, 100, 100, 0, 0);
    run_phase(4, 100, 100, 100, 100);
    reset_400 = 1'b1;
    #1;
    model_reset();
    compare_all();
    pg0 = '0; pg1 = '0; resend = 1'b0; din_bft = '0;
    step();
    step();
    reset_400 = 1'b0;
    run_phase(4, 0, 0, 0, 0);
    run_phase(6, 100, 100, 0, 0);
    run_phase(200, 70, 70, 30, 50);
    run_phase(6, 0, 0, 0, 0);

    // drop counter saturation
    for (int i = 0; i < 70000; i++) begin
      din_bft = {1'b1, 5'd7, 11'd0, 32'(i)};
      step();
    end
    din_bft = '0;
    step();
    step();
    check_val("drop_sat", {48'd0, drop_count}, 64'h0000_0000_0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/leaf_share_arbiter.md
# leaf_share_arbiter

Shares one BFT leaf port between the two pages of a double-subdivided partial-reconfiguration region. On egress, it buffers each page's outbound leaf packets and merges them round-robin onto the single upstream `dout_leaf_interface2bft`, re-driving a packet whenever the BFT asserts `resend`. On ingress, it demultiplexes `din_leaf_bft2interface` to the correct page by destination leaf address. It sits in the static shell between the BFT leaf and the `page_double_subdivide_*` wrapper, in the 400 MHz domain.

## Interface
Parameters:
- `PKT_W`, default 49: leaf packet width. Bit `PKT_W-1` is the valid bit.
- `ADDR_HI`, default 47: MSB of the destination-leaf field.
- `ADDR_LO`, default 43: LSB of the destination-leaf field.
- `PAGE0_ADDR`, default 5'd2: leaf address of page 0.
- `PAGE1_ADDR`, default 5'd3: leaf address of page 1. Must differ from `PAGE0_ADDR`.
- `FIFO_DEPTH`, default 4: per-page egress FIFO depth. Must be a power of 2, ≥2.

Ports:
- `clk_400`, in, 1: the block's only clock.
- `reset_400`, in, 1: asynchronous, active-high reset.
- `din_leaf_bft2interface`, in, PKT_W: packet from the BFT.
- `dout_leaf_interface2bft`, out, PKT_W: merged packet to the BFT.
- `resend`, in, 1: BFT rejected the packet driven in the previous cycle.
- `din_leaf_bft2interface_0` / `_1`, out, PKT_W: demuxed packet to page 0 / page 1.
- `dout_leaf_interface2bft_0` / `_1`, in, PKT_W: outbound packet from page 0 / page 1.
- `resend_0` / `resend_1`, out, 1: the page's packet from the previous cycle was not captured.
- `drop_count`, out, 16: count of ingress packets whose address matched neither page. Saturating.

## Operation
- **Egress capture (per page):**
  - A packet is pushed when its valid bit is 1 and the registered FIFO count is < `FIFO_DEPTH`.
  - A pop in the same cycle does not free space for that cycle's push.
  - If the valid bit is 1 but the FIFO is full, the packet is discarded and `resend_x` is 1 for exactly the next cycle. The page re-presents the packet.
- **Egress FSM states:** IDLE, SEND, RETRY. The FSM holds a saved copy of the last driven packet and a `last_grant` bit.
- **Next-state priority, evaluated every cycle:**
  - `resend` = 1 and the current output valid bit = 1 → RETRY. The output is re-driven from the saved copy and no FIFO is popped.
  - Otherwise, any FIFO is non-empty → SEND. The grant goes to the non-empty page not equal to `last_grant`; if only one page is non-empty, that page gets the grant. The granted FIFO head is popped into the output register and the saved copy, and `last_grant` is updated.
  - Otherwise → IDLE. The output is all-zero.
  - `resend` while the output is invalid (IDLE) is ignored.
- **Repeated resend:** consecutive `resend` cycles keep the FSM in RETRY indefinitely, re-driving the same packet. FIFOs keep filling and then assert page-side `resend_x`.
- **Ingress demux (registered):**
  - A valid packet whose address field equals `PAGE0_ADDR` is forwarded to `_0`; one equal to `PAGE1_ADDR` is forwarded to `_1`.
  - The non-selected page output is all-zero.
  - A valid packet matching neither address is dropped: both outputs are zero and `drop_count` increments, saturating at 16'hFFFF.
  - An invalid packet produces zero on both outputs.
- **Reset (asynchronous, any time, including mid-RETRY):**
  - All outputs go to 0 and the FSM goes to IDLE.
  - FIFOs are emptied (in-flight packets are lost) and `drop_count` is cleared.
  - `last_grant` is set to 1, so page 0 wins the first tie.

## Timing
- **Egress latency:** a packet is presented at cycle t and captured at edge t. It is visible in the FIFO count at t+1, popped at edge t+1, and appears on `dout_leaf_interface2bft` during t+2. Minimum latency is 2 cycles.
- **Throughput:** 1 packet/cycle upstream when `resend` = 0. With both pages continuously valid, grants alternate 0,1,0,1.
- **Retry timing:** `resend` sampled high at edge t re-drives the saved packet during t+1.
- **Page-side resend:** `resend_x` is asserted in the cycle after a rejected capture.
- **Ingress latency:** 1 cycle from `din_leaf_bft2interface` to a page output. `drop_count` updates in the same cycle the packet would have been forwarded.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
1. Reset, then page 0 sends `{1,5'd9,43'h1}` at cycle 0 → `dout_leaf_interface2bft` = that packet at cycle 2 only; `resend_0` stays 0.
2. Both pages valid every cycle for 8 cycles, `resend` = 0 → output alternates p0,p1,…, starting with p0, with no loss and in-order per page.
3. `resend` held high for 3 cycles after the first packet → that packet is re-driven 3 more times; after release, the next packet follows. With page 0 streaming, `resend_0` pulses once the FIFO reaches 4 entries, and the rejected packet is recovered on re-present.
4. Ingress packets to addresses 2, 3, and 7 on consecutive cycles → `_0`, then `_1`, then zero on both; `drop_count` goes from 0 to 1.
5. Assert `reset_400` mid-RETRY with both FIFOs holding 3 entries → all outputs are 0 asynchronously; after release, the output stays 0 until new traffic arrives, and page 0 wins the first tie.
6. Send 70000 unmatched valid ingress packets → `drop_count` = 16'hFFFF and holds.
